// File: rtl/lsu_perf_event_counter.sv
// lsu_perf_event_counter: saturating LSQ/disambiguation event counters with periodic snapshots.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   enable                    event counting enable
//   load_cnt, store_cnt       loads/stores issued this cycle (0..2, 3 counts as 2)
//   load_fwd, load_violation  LSQ event strobes
//   bloom_hit, ss_predict,
//   ss_false_pos, ss_false_neg disambiguation event strobes
//   freeze                    hold counters and timer
//   clear_req / clear_ack     four-phase clear handshake
//   lsq_counters              snapshot: loads, stores, forwarded, violated
//   disambiguation_counters   snapshot: bloom hits, predictions, false pos/neg
//   sample_valid              one-cycle pulse when a new snapshot is visible
//   overflow                  sticky, set when any live counter saturates
package lsu_types;
    typedef struct packed {
        logic [31:0] total_loads;
        logic [31:0] total_stores;
        logic [31:0] forwarded_loads;
        logic [31:0] violated_loads;
        logic [31:0] bloom_filter_hits;
        logic [31:0] store_set_predictions;
        logic [31:0] false_positives;
        logic [31:0] false_negatives;
    } perf_counters_t;
endpackage

module lsu_perf_event_counter
    import lsu_types::*;
#(
    parameter int CNT_W         = 32,
    parameter int SAMPLE_PERIOD = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [1:0]     load_cnt,
    input  logic [1:0]     store_cnt,
    input  logic           load_fwd,
    input  logic           load_violation,
    input  logic           bloom_hit,
    input  logic           ss_predict,
    input  logic           ss_false_pos,
    input  logic           ss_false_neg,
    input  logic           freeze,
    input  logic           clear_req,
    output logic           clear_ack,
    output perf_counters_t lsq_counters,
    output perf_counters_t disambiguation_counters,
    output logic           sample_valid,
    output logic           overflow
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0] LAST = TW'(SAMPLE_PERIOD - 1);

    typedef enum logic [1:0] {RUN, FROZEN, CLEARING} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] live     [8];
    logic [CNT_W-1:0] live_nxt [8];
    logic [CNT_W-1:0] snap     [8];
    logic [1:0]       inc      [8];
    logic [7:0]       sat;
    logic             run, count, tick;

    always_comb begin
        state_nxt = clear_req                      ? CLEARING :
                    state == CLEARING              ? RUN      :
                    (state == RUN && freeze)       ? FROZEN   :
                    (state == FROZEN && !freeze)   ? RUN      : state;
    end

    // clear_req overrides everything in the same cycle, so a clear on the
    // sample-tick cycle suppresses both the snapshot and sample_valid.
    assign run       = state == RUN && !clear_req;
    assign count     = run && enable;
    assign tick      = run && timer == LAST;
    assign clear_ack = state == CLEARING;

    assign inc[0] = count ? (load_cnt  == 2'd3 ? 2'd2 : load_cnt)  : 2'd0;
    assign inc[1] = count ? (store_cnt == 2'd3 ? 2'd2 : store_cnt) : 2'd0;
    assign inc[2] = {1'b0, count & load_fwd};
    assign inc[3] = {1'b0, count & load_violation};
    assign inc[4] = {1'b0, count & bloom_hit};
    assign inc[5] = {1'b0, count & ss_predict};
    assign inc[6] = {1'b0, count & ss_false_pos};
    assign inc[7] = {1'b0, count & ss_false_neg};

    for (genvar i = 0; i < 8; i++) begin : g_cnt
        logic [CNT_W:0] sum;
        assign sum         = {1'b0, live[i]} + (CNT_W+1)'(inc[i]);
        assign sat[i]      = sum[CNT_W];
        assign live_nxt[i] = sat[i] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            timer        <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            live         <= '{default: '0};
            snap         <= '{default: '0};
        end else begin
            state        <= state_nxt;
            sample_valid <= tick;
            if (clear_req) begin
                timer    <= '0;
                overflow <= 1'b0;
                live     <= '{default: '0};
                snap     <= '{default: '0};
            end else if (run) begin
                timer    <= tick ? '0 : timer + 1'b1;
                overflow <= overflow | (|sat);
                live     <= live_nxt;
                if (tick)
                    snap <= live_nxt;
            end
        end
    end

    always_comb begin
        lsq_counters                                 = '0;
        lsq_counters.total_loads                     = 32'(snap[0]);
        lsq_counters.total_stores                    = 32'(snap[1]);
        lsq_counters.forwarded_loads                 = 32'(snap[2]);
        lsq_counters.violated_loads                  = 32'(snap[3]);
        disambiguation_counters                       = '0;
        disambiguation_counters.bloom_filter_hits     = 32'(snap[4]);
        disambiguation_counters.store_set_predictions = 32'(snap[5]);
        disambiguation_counters.false_positives       = 32'(snap[6]);
        disambiguation_counters.false_negatives       = 32'(snap[7]);
    end
endmodule

// File: tb/tb_lsu_perf_event_counter.sv
// tb_lsu_perf_event_counter: directed self-checking bench for lsu_perf_event_counter.
module tb_lsu_perf_event_counter;
    import lsu_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0, freeze = 1'b0, clear_req = 1'b0;
    logic [1:0] load_cnt = '0, store_cnt = '0;
    logic load_fwd = 1'b0, load_violation = 1'b0, bloom_hit = 1'b0;
    logic ss_predict = 1'b0, ss_false_pos = 1'b0, ss_false_neg = 1'b0;

    logic ack, sv, ovf, ack4, sv4, ovf4;
    perf_counters_t lsq, dis, lsq4, dis4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_perf_event_counter #(.CNT_W(32), .SAMPLE_PERIOD(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load_cnt(load_cnt), .store_cnt(store_cnt),
        .load_fwd(load_fwd), .load_violation(load_violation), .bloom_hit(bloom_hit),
        .ss_predict(ss_predict), .ss_false_pos(ss_false_pos), .ss_false_neg(ss_false_neg),
        .freeze(freeze), .clear_req(clear_req), .clear_ack(ack), .lsq_counters(lsq),
        .disambiguation_counters(dis), .sample_valid(sv), .overflow(ovf)
    );

    lsu_perf_event_counter #(.CNT_W(4), .SAMPLE_PERIOD(8)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .load_cnt(load_cnt), .store_cnt(store_cnt),
        .load_fwd(load_fwd), .load_violation(load_violation), .bloom_hit(bloom_hit),
        .ss_predict(ss_predict), .ss_false_pos(ss_false_pos), .ss_false_neg(ss_false_neg),
        .freeze(freeze), .clear_req(clear_req), .clear_ack(ack4), .lsq_counters(lsq4),
        .disambiguation_counters(dis4), .sample_valid(sv4), .overflow(ovf4)
    );

    // ev bits: {fwd, violation, bloom, predict, false_pos, false_neg}
    // snap bytes (MSB first): loads, stores, fwd, viol, bloom, predict, fp, fn
    typedef struct packed {
        logic        en;
        logic [1:0]  ld;
        logic [1:0]  st;
        logic [5:0]  ev;
        logic        sv;
        logic [63:0] snap;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic [1:0] ld, input logic [1:0] st,
                          input logic [5:0] ev, input logic frz, input logic clr);
        enable = en; load_cnt = ld; store_cnt = st;
        {load_fwd, load_violation, bloom_hit, ss_predict, ss_false_pos, ss_false_neg} = ev;
        freeze = frz; clear_req = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_snap(input string tag, input logic [63:0] e);
        perf_counters_t el, ed;
        el = '0;
        ed = '0;
        el.total_loads           = {24'b0, e[63:56]};
        el.total_stores          = {24'b0, e[55:48]};
        el.forwarded_loads       = {24'b0, e[47:40]};
        el.violated_loads        = {24'b0, e[39:32]};
        ed.bloom_filter_hits     = {24'b0, e[31:24]};
        ed.store_set_predictions = {24'b0, e[23:16]};
        ed.false_positives       = {24'b0, e[15:8]};
        ed.false_negatives       = {24'b0, e[7:0]};
        chk({tag, ".lsq"}, lsq, el);
        chk({tag, ".dis"}, dis, ed);
    endtask

    // Reset asserted between clock edges; outputs are checked before any edge.
    task automatic do_reset(input string tag);
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk({tag, ".sv"}, sv, 0);
        chk({tag, ".ack"}, ack, 0);
        chk({tag, ".ovf"}, ovf, 0);
        chk({tag, ".ovf4"}, ovf4, 0);
        chk({tag, ".lsq4"}, lsq4, 0);
        check_snap(tag, 64'h0);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first, pulses;

        vecs[0] = '{1'b1, 2'd1, 2'd0, 6'b100000, 1'b0, 64'h0};
        vecs[1] = '{1'b1, 2'd3, 2'd1, 6'b010000, 1'b0, 64'h0};
        vecs[2] = '{1'b0, 2'd2, 2'd2, 6'b001000, 1'b0, 64'h0};
        vecs[3] = '{1'b1, 2'd0, 2'd3, 6'b001100, 1'b0, 64'h0};
        vecs[4] = '{1'b1, 2'd2, 2'd0, 6'b000011, 1'b0, 64'h0};
        vecs[5] = '{1'b1, 2'd0, 2'd0, 6'b100000, 1'b0, 64'h0};
        vecs[6] = '{1'b1, 2'd0, 2'd0, 6'b001000, 1'b0, 64'h0};
        vecs[7] = '{1'b1, 2'd1, 2'd1, 6'b000100, 1'b1, 64'h06_04_02_01_02_02_01_01};
        vecs[8] = '{1'b1, 2'd2, 2'd0, 6'b000000, 1'b0, 64'h06_04_02_01_02_02_01_01};
        for (int i = 9; i < 15; i++)
            vecs[i] = '{1'b1, 2'd0, 2'd0, 6'b000000, 1'b0, 64'h06_04_02_01_02_02_01_01};
        vecs[15] = '{1'b1, 2'd0, 2'd2, 6'b000000, 1'b1, 64'h08_06_02_01_02_02_01_01};

        // Table: mixed events over two sample periods
        do_reset("rst0");
        for (int i = 0; i < 16; i++) begin
            set_in(vecs[i].en, vecs[i].ld, vecs[i].st, vecs[i].ev, 0, 0);
            step();
            chk($sformatf("vec%0d.sv", i), sv, vecs[i].sv);
            chk($sformatf("vec%0d.ovf", i), ovf, 0);
            check_snap($sformatf("vec%0d", i), vecs[i].snap);
        end

        // Saturation on the 4-bit instance: 2 stores/cycle for 9 cycles
        do_reset("rst_sat");
        for (int k = 1; k <= 9; k++) begin
            set_in(1, 0, 2, 0, 0, 0);
            step();
            chk($sformatf("sat%0d.ovf4", k), ovf4, k >= 8);
            chk($sformatf("sat%0d.sv4", k), sv4, k == 8);
            if (k == 8) begin
                chk("sat.stores4", lsq4.total_stores, 15);
                chk("sat.stores32", lsq.total_stores, 16);
                chk("sat.ovf32", ovf, 0);
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) step();
        chk("sat.ovf4_sticky", ovf4, 1);
        chk("sat.stores4_hold", lsq4.total_stores, 15);

        // Clear handshake with freeze held; events during clear are dropped
        chk("clr.ack_idle", ack, 0);
        for (int k = 1; k <= 3; k++) begin
            set_in(1, 2, 0, 0, 1, 1);
            step();
            chk($sformatf("clr%0d.ack", k), ack, 1);
            chk($sformatf("clr%0d.ack4", k), ack4, 1);
            chk($sformatf("clr%0d.ovf4", k), ovf4, 0);
            chk($sformatf("clr%0d.lsq4", k), lsq4, 0);
            check_snap($sformatf("clr%0d", k), 64'h0);
        end
        set_in(1, 1, 0, 0, 0, 0);
        step();
        chk("clr_exit.ack", ack, 0);
        chk("clr_exit.sv", sv, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("post_clr%0d.sv", k), sv, k == 8);
        end
        check_snap("post_clr", 64'h08_00_00_00_00_00_00_00);

        // Freeze for 5 cycles starting at timer=3 delays the sample by 5
        do_reset("rst_frz");
        first = 0;
        pulses = 0;
        for (int c = 1; c <= 16; c++) begin
            set_in(1, 0, 0, 6'b001000, c >= 4 && c <= 8, 0);
            step();
            if (sv) begin
                pulses++;
                if (first == 0) begin
                    first = c;
                    check_snap("frz", 64'h00_00_00_00_08_00_00_00);
                end
            end
        end
        chk("frz.first_sample", first, 13);
        chk("frz.pulses", pulses, 1);

        // Clear requested on the sample-tick cycle
        do_reset("rst_ctick");
        for (int k = 1; k <= 7; k++) begin
            set_in(1, 1, 0, 0, 0, 0);
            step();
        end
        set_in(1, 1, 0, 0, 0, 1);
        step();
        chk("ctick.sv", sv, 0);
        chk("ctick.ack", ack, 1);
        check_snap("ctick", 64'h0);
        set_in(1, 1, 0, 0, 0, 0);
        step();
        chk("ctick_exit.sv", sv, 0);
        chk("ctick_exit.ack", ack, 0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("ctick_run%0d.sv", k), sv, k == 8);
        end
        check_snap("ctick_run", 64'h08_00_00_00_00_00_00_00);

        // Two loads/cycle for one period, then a mid-period reset
        do_reset("rst_ld");
        for (int k = 1; k <= 8; k++) begin
            set_in(1, 2, 0, 0, 0, 0);
            step();
            chk($sformatf("ld%0d.sv", k), sv, k == 8);
            chk($sformatf("ld%0d.ovf4", k), ovf4, k == 8);
        end
        check_snap("ld", 64'h10_00_00_00_00_00_00_00);
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("ld9.sv", sv, 0);
        do_reset("rst_mid");
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("mid%0d.sv", k), sv, k == 8);
        end
        check_snap("mid", 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
